memory_stage_hs: RTL and testbench

Parametrised single-clock successor to the memory stage. Adds a valid/ready handshake toward execute and writeback, configurable RAM read latency, address-range fault detection and a writeback tag passthrough. Keeps a read-only port B for display/debug readout.
- Sits between the execute and writeback stages.
- Owns the data RAM.

---
 rtl/memory_stage_pkg.sv | 19 +
 rtl/memory_stage_hs_dp_ram.sv | 54 +++++
 rtl/memory_stage_hs.sv | 154 +++++++++++++++
 tb/tb_memory_stage_hs.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared constants for the handshaked memory stage: default widths and FSM encodings.
package memory_stage_pkg;

   localparam int unsigned DATA_W_DEF   = 24;
   localparam int unsigned ADDR_W_DEF   = 17;
   localparam int unsigned RD_W_DEF     = 4;
   localparam int unsigned DEPTH_DEF    = 90000;
   localparam int unsigned READ_LAT_DEF = 1;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
   localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;

   // Down-counter wide enough for READ_LAT-1 with READ_LAT in 1..4.
   localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/memory_stage_hs_dp_ram.sv
// Dual-port data RAM: port A read/write with READ_LAT total load latency,
// port B registered read-only with out-of-range addresses returning zero.
module dp_ram
   import memory_stage_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned READ_LAT = READ_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_rdata
);

   logic [DATA_W-1:0] mem    [DEPTH];
   logic [DATA_W-1:0] a_pipe [READ_LAT];
   logic              b_in_range;

   assign b_in_range = 32'(b_addr) < DEPTH;
   assign a_rdata    = a_pipe[READ_LAT-1];

   // Port A: write on enable, read register only reloads on a load so the
   // pipeline settles on one word and stays stable while the result is held.
   always_ff @(posedge clk) begin
      if (a_en && a_we) begin
         mem[a_addr] <= a_wdata;
      end
      if (a_en && !a_we) begin
         a_pipe[0] <= mem[a_addr];
      end
      for (int i = 1; i < int'(READ_LAT); i++) begin
         a_pipe[i] <= a_pipe[i-1];
      end
   end

   // Port B: read-before-write, so a same-cycle port A write shows up next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         b_rdata <= '0;
      end else if (b_in_range) begin
         b_rdata <= mem[b_addr];
      end else begin
         b_rdata <= '0;
      end
   end

endmodule

// File: rtl/memory_stage_hs.sv
// Memory stage between execute and writeback with valid/ready handshakes,
// configurable load latency, address-range faulting and a debug read port.
module memory_stage_hs
   import memory_stage_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned READ_LAT = READ_LAT_DEF,
   parameter int unsigned RD_W     = RD_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              read_enable,
   input  logic              write_enable,
   input  logic              mem_to_reg,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] write_data_a,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_reg_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_reg_write,
   output logic              addr_fault,
   input  logic [ADDR_W-1:0] address_b,
   output logic [DATA_W-1:0] read_data_b
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(READ_LAT - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  alu_q, alu_d;
   logic [DATA_W-1:0]  ram_rdata;
   logic               sel_mem_q, sel_mem_d;
   logic               valid_d, fault_d, reg_write_d;
   logic [RD_W-1:0]    rd_d;
   logic               accept, take;
   logic               in_range, is_store, is_load, mem_load, needs_wait, ram_en;

   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign accept     = in_valid && in_ready;
   assign in_range   = alu_result < DATA_W'(DEPTH);
   assign is_store   = write_enable;
   assign is_load    = read_enable && !write_enable;
   assign mem_load   = is_load && mem_to_reg;
   assign needs_wait = mem_load && in_range && (READ_LAT > 1);
   assign ram_en     = accept && !reset && in_range && (is_store || mem_load);

   // Loaded words come straight from the RAM output registers, everything else
   // from the value captured at acceptance.
   assign result = sel_mem_q ? ram_rdata : alu_q;

   // Next-state and capture logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = out_valid;
      alu_d       = alu_q;
      sel_mem_d   = sel_mem_q;
      fault_d     = addr_fault;
      rd_d        = out_rd;
      reg_write_d = out_reg_write;
      take        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            take = accept;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_HOLD;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               if (accept) begin
                  take = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (take) begin
         rd_d        = in_rd;
         reg_write_d = in_reg_write && !is_store;
         fault_d     = !in_range && (is_store || is_load);
         alu_d       = (mem_load && !in_range) ? '0 : alu_result;
         sel_mem_d   = mem_load && in_range;
         if (needs_wait) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
            valid_d = 1'b0;
         end else begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         out_valid     <= 1'b0;
         alu_q         <= '0;
         sel_mem_q     <= 1'b0;
         addr_fault    <= 1'b0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         out_valid     <= valid_d;
         alu_q         <= alu_d;
         sel_mem_q     <= sel_mem_d;
         addr_fault    <= fault_d;
         out_rd        <= rd_d;
         out_reg_write <= reg_write_d;
      end
   end

   dp_ram #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .a_en    (ram_en),
      .a_we    (is_store),
      .a_addr  (alu_result[ADDR_W-1:0]),
      .a_wdata (write_data_a),
      .a_rdata (ram_rdata),
      .b_addr  (address_b),
      .b_rdata (read_data_b)
   );

endmodule

// File: tb/tb_memory_stage_hs.sv
// Scoreboard bench for memory_stage_hs: one instance with READ_LAT=1, one with READ_LAT=3.
module tb_memory_stage_hs;

   typedef struct packed {
      logic [23:0] result;
      logic [3:0]  rd;
      logic        rw;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid      [2];
   logic        in_ready      [2];
   logic        read_enable   [2];
   logic        write_enable  [2];
   logic        mem_to_reg    [2];
   logic [23:0] alu_result    [2];
   logic [23:0] write_data_a  [2];
   logic [3:0]  in_rd         [2];
   logic        in_reg_write  [2];
   logic        out_valid     [2];
   logic        out_ready     [2];
   logic [23:0] result        [2];
   logic [3:0]  out_rd        [2];
   logic        out_reg_write [2];
   logic        addr_fault    [2];
   logic [16:0] address_b     [2];
   logic [23:0] read_data_b   [2];

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q0[$];
   exp_t exp_q1[$];

   always #5 clk = ~clk;

   memory_stage_hs #(.READ_LAT(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .read_enable(read_enable[0]), .write_enable(write_enable[0]), .mem_to_reg(mem_to_reg[0]),
      .alu_result(alu_result[0]), .write_data_a(write_data_a[0]),
      .in_rd(in_rd[0]), .in_reg_write(in_reg_write[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
      .out_rd(out_rd[0]), .out_reg_write(out_reg_write[0]), .addr_fault(addr_fault[0]),
      .address_b(address_b[0]), .read_data_b(read_data_b[0])
   );

   memory_stage_hs #(.READ_LAT(3)) u_dut_l3 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .read_enable(read_enable[1]), .write_enable(write_enable[1]), .mem_to_reg(mem_to_reg[1]),
      .alu_result(alu_result[1]), .write_data_a(write_data_a[1]),
      .in_rd(in_rd[1]), .in_reg_write(in_reg_write[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
      .out_rd(out_rd[1]), .out_reg_write(out_reg_write[1]), .addr_fault(addr_fault[1]),
      .address_b(address_b[1]), .read_data_b(read_data_b[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
   endtask

   function automatic exp_t mk(input logic [23:0] r, input logic [3:0] rd, input logic rw, input logic f);
      return '{result: r, rd: rd, rw: rw, fault: f};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one transaction, wait (bounded) for acceptance, then drop in_valid.
   task automatic send(input int d, input logic we, input logic re, input logic m2r,
                       input logic [23:0] alu, input logic [23:0] wd, input logic [3:0] rd,
                       input logic rw, input logic push, input exp_t e, output logic v_acc);
      logic got;
      write_enable[d] = we;
      read_enable[d]  = re;
      mem_to_reg[d]   = m2r;
      alu_result[d]   = alu;
      write_data_a[d] = wd;
      in_rd[d]        = rd;
      in_reg_write[d] = rw;
      in_valid[d]     = 1'b1;
      if (push) begin
         if (d == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
      got   = 1'b0;
      v_acc = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            got   = 1'b1;
            v_acc = out_valid[d];
         end
      end
      if (!got) check("accept_timeout", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   // Monitors: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (!reset && out_valid[0] && out_ready[0]) begin
         if (exp_q0.size() == 0) begin
            check("l1_unexpected_output", 32'(exp_q0.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q0.pop_front();
            check("l1_result", 32'(result[0]), 32'(e.result));
            check("l1_out_rd", 32'(out_rd[0]), 32'(e.rd));
            check("l1_out_reg_write", 32'(out_reg_write[0]), 32'(e.rw));
            check("l1_addr_fault", 32'(addr_fault[0]), 32'(e.fault));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && out_valid[1] && out_ready[1]) begin
         if (exp_q1.size() == 0) begin
            check("l3_unexpected_output", 32'(exp_q1.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q1.pop_front();
            check("l3_result", 32'(result[1]), 32'(e.result));
            check("l3_out_rd", 32'(out_rd[1]), 32'(e.rd));
            check("l3_out_reg_write", 32'(out_reg_write[1]), 32'(e.rw));
            check("l3_addr_fault", 32'(addr_fault[1]), 32'(e.fault));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic v;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; read_enable[d] = 1'b0; write_enable[d] = 1'b0;
         mem_to_reg[d] = 1'b0; alu_result[d] = '0; write_data_a[d] = '0;
         in_rd[d] = '0; in_reg_write[d] = 1'b0; out_ready[d] = 1'b1;
         address_b[d] = 17'h1FFFF;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready[0]), 32'd1);
      check("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check("rst_result", 32'(result[0]), 32'd0);
      check("rst_read_data_b", 32'(read_data_b[0]), 32'd0);
      check("rst_l3_out_valid", 32'(out_valid[1]), 32'd0);
      tick();

      // Store then load of the same address on consecutive cycles.
      send(0, 1, 0, 0, 24'd2, 24'h00ABCD, 4'd3, 1, 1, mk(24'd2, 4'd3, 0, 0), v);
      send(0, 0, 1, 1, 24'd2, 24'h0, 4'd5, 1, 1, mk(24'h00ABCD, 4'd5, 1, 0), v);
      @(negedge clk);
      check("l1_load_latency_valid", 32'(out_valid[0]), 32'd1);
      tick();

      // Address-range faults; port B shows an in-range neighbour is untouched.
      send(0, 1, 0, 0, 24'd89999, 24'h0F0F0F, 4'd1, 0, 1, mk(24'd89999, 4'd1, 0, 0), v);
      send(0, 0, 1, 1, 24'd90000, 24'h0, 4'd6, 1, 1, mk(24'd0, 4'd6, 1, 1), v);
      send(0, 1, 0, 0, 24'd90001, 24'h555555, 4'd7, 1, 1, mk(24'd90001, 4'd7, 0, 1), v);
      address_b[0] = 17'd89999;
      tick();
      @(negedge clk);
      check("portb_89999_unchanged", 32'(read_data_b[0]), 32'h0F0F0F);
      tick();

      // Back-to-back pass-through results.
      for (int k = 1; k <= 3; k++) begin
         send(0, 0, 0, 0, 24'd1, 24'h0, 4'(k), 1, 1, mk(24'd1, 4'(k), 1, 0), v);
         if (k > 1) check("b2b_valid_at_accept", 32'(v), 32'd1);
      end
      @(negedge clk);
      check("b2b_third_valid", 32'(out_valid[0]), 32'd1);
      tick();
      tick();

      // Port B read colliding with a port A write returns the old word first.
      address_b[0] = 17'd2;
      tick();
      send(0, 1, 0, 0, 24'd2, 24'h111111, 4'd8, 1, 1, mk(24'd2, 4'd8, 0, 0), v);
      @(negedge clk);
      check("portb_collide_old", 32'(read_data_b[0]), 32'h00ABCD);
      tick();
      @(negedge clk);
      check("portb_collide_new", 32'(read_data_b[0]), 32'h111111);
      tick();

      // READ_LAT=3 load with writeback stalled.
      send(1, 1, 0, 0, 24'd2, 24'h00ABCD, 4'd2, 1, 1, mk(24'd2, 4'd2, 0, 0), v);
      tick();
      out_ready[1] = 1'b0;
      send(1, 0, 1, 1, 24'd2, 24'h0, 4'd9, 1, 1, mk(24'h00ABCD, 4'd9, 1, 0), v);
      @(negedge clk);
      check("wait1_in_ready", 32'(in_ready[1]), 32'd0);
      check("wait1_out_valid", 32'(out_valid[1]), 32'd0);
      tick();
      @(negedge clk);
      check("wait2_in_ready", 32'(in_ready[1]), 32'd0);
      check("wait2_out_valid", 32'(out_valid[1]), 32'd0);
      tick();
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid[1]), 32'd1);
      check("hold_in_ready", 32'(in_ready[1]), 32'd0);
      check("hold_result", 32'(result[1]), 32'h00ABCD);
      tick();
      @(negedge clk);
      check("hold2_out_valid", 32'(out_valid[1]), 32'd1);
      check("hold2_result", 32'(result[1]), 32'h00ABCD);
      tick();
      out_ready[1] = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(in_ready[1]), 32'd1);
      tick();

      // Reset during WAIT discards the load but keeps committed stores.
      send(1, 1, 0, 0, 24'd5, 24'h222222, 4'd4, 1, 1, mk(24'd5, 4'd4, 0, 0), v);
      tick();
      send(1, 0, 1, 1, 24'd5, 24'h0, 4'd11, 1, 0, mk(24'd0, 4'd0, 0, 0), v);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid[1]), 32'd0);
      check("midrst_in_ready", 32'(in_ready[1]), 32'd1);
      tick();
      @(negedge clk);
      check("midrst_still_idle", 32'(out_valid[1]), 32'd0);
      tick();
      address_b[1] = 17'd5;
      tick();
      @(negedge clk);
      check("midrst_portb_persist", 32'(read_data_b[1]), 32'h222222);
      tick();
      send(1, 0, 1, 1, 24'd5, 24'h0, 4'd10, 1, 1, mk(24'h222222, 4'd10, 1, 0), v);

      repeat (8) tick();
      check("l1_queue_drained", 32'(exp_q0.size()), 32'd0);
      check("l3_queue_drained", 32'(exp_q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
